// File: rtl/cb_config_loader.sv
// Assembles a CONF_WIDTH-bit connection-block word from a DW-bit stream, strobes cset, then forwards
// later words through a one-entry output register (1 cycle latency, din_ready drops while dout stalls).
module cb_config_loader #(
  parameter int CONF_WIDTH = 88,
  parameter int DW         = 8,
  localparam int NW        = (CONF_WIDTH + DW - 1) / DW,
  localparam int CW        = $clog2(NW + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic [DW-1:0]         din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [DW-1:0]         dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  start_out,
  output logic [CONF_WIDTH-1:0] c,
  output logic                  cset,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT, S_PASS} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CONF_WIDTH-1:0] c_q, c_d;
  logic [DW-1:0]         dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  cset_q, cset_d;
  logic                  start_out_q, start_out_d;
  logic                  busy_q, busy_d;
  logic                  din_ready_w;
  logic                  in_xfer;

  // A restart pulse always wins: nothing is accepted in the cycle it is seen.
  always_comb begin
    din_ready_w = 1'b0;
    if (!cfg_start) begin
      case (state_q)
        S_LOAD:  din_ready_w = 1'b1;
        S_PASS:  din_ready_w = !dout_valid_q || dout_ready;
        default: din_ready_w = 1'b0;
      endcase
    end
  end

  assign in_xfer = din_valid && din_ready_w;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    c_d          = c_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    cset_d       = 1'b0;
    start_out_d  = cfg_start;
    if (cfg_start) begin
      state_d      = S_LOAD;
      cnt_d        = '0;
      dout_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (in_xfer) begin
            // Bits of the last word that fall beyond CONF_WIDTH simply have no destination.
            for (int i = 0; i < CONF_WIDTH; i++) begin
              if ((i / DW) == int'(cnt_q)) c_d[i] = din[i % DW];
            end
            if (cnt_q == CW'(NW - 1)) begin
              state_d = S_COMMIT;
              cset_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_COMMIT: state_d = S_PASS;
        S_PASS: begin
          if (in_xfer) begin
            dout_d       = din;
            dout_valid_d = 1'b1;
          end else if (dout_ready) begin
            dout_valid_d = 1'b0;
          end
        end
        default: state_d = state_q;
      endcase
    end
    busy_d = (state_d == S_LOAD) || (state_d == S_COMMIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      c_q          <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      cset_q       <= 1'b0;
      start_out_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      c_q          <= c_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      cset_q       <= cset_d;
      start_out_q  <= start_out_d;
      busy_q       <= busy_d;
    end
  end

  assign din_ready  = din_ready_w;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign start_out  = start_out_q;
  assign c          = c_q;
  // A restart landing on the commit cycle cancels the strobe.
  assign cset       = cset_q && !cfg_start;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cb_config_loader.sv
// Bench for cb_config_loader: a phase-level loader model feeds expectation queues that a monitor drains.
module tb_cb_config_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start, din_valid, dout_ready;
  logic [7:0]  din;
  logic        din_ready, dout_valid, start_out, cset, busy;
  logic [7:0]  dout;
  logic [87:0] c;

  logic        b_cfg_start, b_din_valid, b_dout_ready;
  logic [7:0]  b_din;
  logic        b_din_ready, b_dout_valid, b_start_out, b_cset, b_busy;
  logic [7:0]  b_dout;
  logic [89:0] b_c;

  cb_config_loader #(.CONF_WIDTH(88), .DW(8)) u_dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .start_out(start_out), .c(c), .cset(cset), .busy(busy));

  cb_config_loader #(.CONF_WIDTH(90), .DW(8)) u_dut90 (
    .clk(clk), .rst(rst), .cfg_start(b_cfg_start), .din(b_din), .din_valid(b_din_valid),
    .din_ready(b_din_ready), .dout(b_dout), .dout_valid(b_dout_valid), .dout_ready(b_dout_ready),
    .start_out(b_start_out), .c(b_c), .cset(b_cset), .busy(b_busy));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cset   = 0;
  int n_exp_cset = 0;
  int n_dout   = 0;
  int rdy_mode = 0;

  logic [87:0] cq[$];
  logic [7:0]  dq[$];

  typedef enum {M_IDLE, M_LOAD, M_COMMIT, M_PASS} mphase_t;
  mphase_t     m_phase = M_IDLE;
  int          m_cnt = 0;
  logic [87:0] m_c = '0;
  logic        m_prev_start = 1'b0;
  logic        m_commit_pend = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       dout_ready = 1'b1;
      1:       dout_ready = !dout_ready;
      default: dout_ready = ($urandom % 3) != 0;
    endcase
  endtask

  // Reference model: what the loader should do this cycle, from its phase and the bitstream rules.
  always @(negedge clk) begin
    logic exp_rdy;
    logic acc;
    if (rst) begin
      if (m_commit_pend) n_exp_cset--;
      m_phase = M_IDLE; m_cnt = 0; m_c = '0; m_prev_start = 1'b0; m_commit_pend = 1'b0;
      cq.delete(); dq.delete();
      check("rst_outputs", {c, din_ready, dout_valid, cset, busy, start_out}, '0);
    end else begin
      if (cfg_start)                exp_rdy = 1'b0;
      else if (m_phase == M_LOAD)   exp_rdy = 1'b1;
      else if (m_phase == M_PASS)   exp_rdy = (dq.size() == 0) || dout_ready;
      else                          exp_rdy = 1'b0;
      check("din_ready", din_ready, exp_rdy);
      check("busy", busy, (m_phase == M_LOAD) || (m_phase == M_COMMIT));
      check("start_out", start_out, m_prev_start);
      check("c_stable", c, m_c);
      m_prev_start = cfg_start;
      acc = din_valid && exp_rdy;
      if (cfg_start) begin
        if (m_commit_pend) begin
          void'(cq.pop_back());
          n_exp_cset--;
        end
        if (dq.size() != 0 && !dout_ready) dq.delete();
        m_commit_pend = 1'b0;
        m_phase = M_LOAD;
        m_cnt = 0;
      end else begin
        m_commit_pend = 1'b0;
        case (m_phase)
          M_LOAD: if (acc) begin
            m_c[m_cnt*8 +: 8] = din;
            m_cnt++;
            if (m_cnt == 11) begin
              m_phase = M_COMMIT;
              cq.push_back(m_c);
              n_exp_cset++;
              m_commit_pend = 1'b1;
            end
          end
          M_COMMIT: m_phase = M_PASS;
          M_PASS:   if (acc) dq.push_back(din);
          default:  m_phase = m_phase;
        endcase
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a commit or a downstream transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (cset) begin
        n_cset++;
        check("cset_expected", cq.size() != 0, 1'b1);
        if (cq.size() != 0) check("cset_c", c, cq.pop_front());
      end
      if (dout_valid && dout_ready) begin
        n_dout++;
        check("dout_expected", dq.size() != 0, 1'b1);
        if (dq.size() != 0) check("dout", dout, dq.pop_front());
      end
      if (dout_valid && !dout_ready) check("stall_din_ready", din_ready, 1'b0);
    end
  end

  task automatic send_word(input logic [7:0] w);
    logic got;
    got = 1'b0;
    din = w;
    din_valid = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = din_valid && din_ready;
      step();
    end
    din_valid = 1'b0;
    if (!got) check("send_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    int csets_before;
    int douts_before;
    logic [7:0]  w90[12];
    logic [89:0] e90;

    rst = 1'b1; cfg_start = 0; din_valid = 0; din = '0; dout_ready = 1'b1;
    b_cfg_start = 0; b_din_valid = 0; b_din = '0; b_dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_c", c, 88'h0);
    check("reset_flags", {din_ready, dout_valid, cset, busy, start_out}, 5'b0);
    check("reset_dout", dout, 8'h0);
    rst = 1'b0;

    // Idle rejection
    din_valid = 1'b1; din = 8'h77;
    repeat (3) step();
    din_valid = 1'b0;

    // Continuous load 0x01..0x0B, din_valid held into the commit cycle
    cfg_start = 1'b1; step(); cfg_start = 1'b0;
    din_valid = 1'b1;
    for (int k = 0; k < 11; k++) begin
      din = 8'(k + 1);
      step();
    end
    din = 8'hEE;
    @(negedge clk);
    check("load_cset", cset, 1'b1);
    check("load_c_lo", c[7:0], 8'h01);
    check("load_c_hi", c[87:80], 8'h0B);
    check("commit_din_ready", din_ready, 1'b0);
    step();
    @(negedge clk);
    check("load_cset_once", cset, 1'b0);
    check("load_busy_low", busy, 1'b0);
    step();
    din_valid = 1'b0;
    repeat (2) step();

    // Chain forward with toggling backpressure
    rdy_mode = 1;
    douts_before = n_dout;
    send_word(8'hA5);
    send_word(8'h5A);
    send_word(8'h3C);
    repeat (4) step();
    check("fwd_count", n_dout - douts_before, 3);
    rdy_mode = 0;
    step();

    // Restart mid-load
    csets_before = n_cset;
    cfg_start = 1'b1; step(); cfg_start = 1'b0;
    din_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin din = 8'($urandom); step(); end
    cfg_start = 1'b1; step(); cfg_start = 1'b0;
    for (int k = 0; k < 11; k++) begin din = 8'hF0 + 8'(k); step(); end
    din_valid = 1'b0;
    repeat (3) step();
    check("restart_cset_count", n_cset - csets_before, 1);
    check("restart_c_lo", c[7:0], 8'hF0);
    check("restart_c_hi", c[87:80], 8'hFA);

    // Async reset mid-load
    csets_before = n_cset;
    cfg_start = 1'b1; step(); cfg_start = 1'b0;
    din_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin din = 8'h30 + 8'(k); step(); end
    #2 rst = 1'b1;
    #1;
    check("arst_c", c, 88'h0);
    check("arst_din_ready", din_ready, 1'b0);
    check("arst_dout_valid", dout_valid, 1'b0);
    step(); step();
    rst = 1'b0;
    repeat (5) step();
    din_valid = 1'b0;
    repeat (15) step();
    check("arst_no_cset", n_cset - csets_before, 0);

    // Randomized traffic
    rdy_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      cfg_start = (i == 0) || (($urandom % 200) == 0);
      din_valid = ($urandom % 4) != 0;
      din = 8'($urandom);
      step();
    end
    cfg_start = 1'b0; din_valid = 1'b0; rdy_mode = 0;
    repeat (6) step();
    check("drain_dout", dq.size(), 0);
    check("drain_cset", cq.size(), 0);
    check("cset_total", n_cset, n_exp_cset);

    // Partial last word on the 90-bit instance
    e90 = '0;
    for (int k = 0; k < 12; k++) w90[k] = (k == 11) ? 8'hFF : 8'($urandom);
    for (int k = 0; k < 11; k++) e90[k*8 +: 8] = w90[k];
    e90[89:88] = 2'b11;
    b_cfg_start = 1'b1; step(); b_cfg_start = 1'b0;
    b_din_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      b_din = w90[k];
      @(negedge clk);
      check("p90_din_ready", b_din_ready, 1'b1);
      check("p90_no_early_cset", b_cset, 1'b0);
      step();
    end
    b_din_valid = 1'b0;
    @(negedge clk);
    check("p90_cset", b_cset, 1'b1);
    check("p90_c", b_c, e90);
    check("p90_top_bits", b_c[89:88], 2'b11);
    step();
    @(negedge clk);
    check("p90_cset_once", b_cset, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
